dest_scoreboard: RTL and testbench

DEST_SCOREBOARD -- requirements
Module: dest_scoreboard

---
 rtl/dest_scoreboard_if.sv | 34 +++
 rtl/dest_scoreboard.sv | 97 +++++++++
 tb/tb_dest_scoreboard.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dest_scoreboard_if.sv
// Decode-side handshake bundle for the destination scoreboard: the decode
// stage presents its instruction fields and receives stall plus the
// in-flight slot status and register-file write port.
interface dest_scoreboard_if;
  logic        id_valid;
  logic [2:0]  id_rd;
  logic        id_we;
  logic        id_is_load;
  logic [2:0]  id_rs;
  logic [2:0]  id_rt;
  logic        id_rs_used;
  logic        id_rt_used;
  logic        flush;
  logic        clr_cnt;
  logic        stall;
  logic        ex_vld;
  logic        mem_vld;
  logic        wb_vld;
  logic [2:0]  wb_rd;
  logic        wb_we;
  logic [15:0] stall_cnt;

  modport master (
    output id_valid, id_rd, id_we, id_is_load, id_rs, id_rt,
           id_rs_used, id_rt_used, flush, clr_cnt,
    input  stall, ex_vld, mem_vld, wb_vld, wb_rd, wb_we, stall_cnt
  );

  modport slave (
    input  id_valid, id_rd, id_we, id_is_load, id_rs, id_rt,
           id_rs_used, id_rt_used, flush, clr_cnt,
    output stall, ex_vld, mem_vld, wb_vld, wb_rd, wb_we, stall_cnt
  );
endinterface

// File: rtl/dest_scoreboard.sv
// Destination scoreboard for a 3-stage (EX/MEM/WB) pipeline. Tracks pending
// register writes, raises a combinational decode stall on RAW hazards and
// counts stall cycles. FWD_EN selects between no forwarding (any in-flight
// writer of a source stalls) and full forwarding (only load-use stalls).
module dest_scoreboard #(
  parameter bit FWD_EN = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  dest_scoreboard_if.slave sb
);

  // Slot EX is _p0, MEM is _p1, WB is _p2. The load flag is only consulted
  // while the writer sits in EX, so later slots carry just vld and rd.
  logic       vld_p0, ld_p0;
  logic [2:0] rd_p0;
  logic       vld_p1;
  logic [2:0] rd_p1;
  logic       vld_p2;
  logic [2:0] rd_p2;

  logic [15:0] stall_cnt_r;
  logic        rs_haz, rt_haz;
  logic        stall, iss;

  function automatic logic hit(input logic v, input logic [2:0] rd,
                               input logic [2:0] x);
    return v && (rd == x);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Hazard detection and issue decision for the instruction in decode.
  always_comb begin
    rs_haz = 1'b0;
    rt_haz = 1'b0;
    if (FWD_EN) begin
      rs_haz = hit(vld_p0 & ld_p0, rd_p0, sb.id_rs);
      rt_haz = hit(vld_p0 & ld_p0, rd_p0, sb.id_rt);
    end else begin
      // No bypass from WB: the register file only writes at the end of WB.
      rs_haz = hit(vld_p0, rd_p0, sb.id_rs) | hit(vld_p1, rd_p1, sb.id_rs) |
               hit(vld_p2, rd_p2, sb.id_rs);
      rt_haz = hit(vld_p0, rd_p0, sb.id_rt) | hit(vld_p1, rd_p1, sb.id_rt) |
               hit(vld_p2, rd_p2, sb.id_rt);
    end
    stall = sb.id_valid & ~sb.flush &
            ((sb.id_rs_used & rs_haz) | (sb.id_rt_used & rt_haz));
    iss   = sb.id_valid & sb.id_we & ~stall & ~sb.flush;
  end

  // Slot pipeline: bubbles and flushed slots are written as all-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      rd_p0  <= 3'd0;
      ld_p0  <= 1'b0;
      vld_p1 <= 1'b0;
      rd_p1  <= 3'd0;
      vld_p2 <= 1'b0;
      rd_p2  <= 3'd0;
    end else begin
      // EX stage boundary
      vld_p0 <= iss;
      rd_p0  <= iss ? sb.id_rd : 3'd0;
      ld_p0  <= iss ? sb.id_is_load : 1'b0;
      // MEM stage boundary
      vld_p1 <= sb.flush ? 1'b0 : vld_p0;
      rd_p1  <= sb.flush ? 3'd0 : rd_p0;
      // WB stage boundary: the MEM writer commits even on flush
      vld_p2 <= vld_p1;
      rd_p2  <= rd_p1;
    end
  end

  // Saturating stall-cycle counter; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 16'd0;
    end else if (sb.clr_cnt) begin
      stall_cnt_r <= 16'd0;
    end else if (stall) begin
      stall_cnt_r <= sat_inc(stall_cnt_r);
    end
  end

  assign sb.stall     = stall;
  assign sb.ex_vld    = vld_p0;
  assign sb.mem_vld   = vld_p1;
  assign sb.wb_vld    = vld_p2;
  assign sb.wb_rd     = rd_p2;
  assign sb.wb_we     = vld_p2;
  assign sb.stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_dest_scoreboard.sv
// Bench for dest_scoreboard: one instance without forwarding (dut0) and one
// with forwarding (dut1) share the same decode stimulus. A queue-based model
// of in-flight writes (tagged by instance and age) predicts every output at
// each falling edge; directed scenarios add hand-computed literal checks.
module tb_dest_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid, id_we, id_is_load, id_rs_used, id_rt_used, flush, clr_cnt;
  logic [2:0] id_rd, id_rs, id_rt;

  dest_scoreboard_if if0();
  dest_scoreboard_if if1();

  assign if0.id_valid = id_valid;     assign if1.id_valid = id_valid;
  assign if0.id_rd = id_rd;           assign if1.id_rd = id_rd;
  assign if0.id_we = id_we;           assign if1.id_we = id_we;
  assign if0.id_is_load = id_is_load; assign if1.id_is_load = id_is_load;
  assign if0.id_rs = id_rs;           assign if1.id_rs = id_rs;
  assign if0.id_rt = id_rt;           assign if1.id_rt = id_rt;
  assign if0.id_rs_used = id_rs_used; assign if1.id_rs_used = id_rs_used;
  assign if0.id_rt_used = id_rt_used; assign if1.id_rt_used = id_rt_used;
  assign if0.flush = flush;           assign if1.flush = flush;
  assign if0.clr_cnt = clr_cnt;       assign if1.clr_cnt = clr_cnt;

  dest_scoreboard #(.FWD_EN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .sb(if0.slave));
  dest_scoreboard #(.FWD_EN(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .sb(if1.slave));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each issued write lives for three cycles (age 1=EX, 2=MEM, 3=WB).
  typedef struct {
    int         m;
    logic [2:0] rd;
    bit         ld;
    int         age;
  } wr_t;

  wr_t infl[$];
  wr_t nw;
  int  mcnt[2];
  bit  mst0, mst1;

  function automatic bit m_stall(input int m);
    if (!id_valid || flush) return 1'b0;
    foreach (infl[i]) begin
      if (infl[i].m == m) begin
        bit src;
        src = (id_rs_used && infl[i].rd == id_rs) || (id_rt_used && infl[i].rd == id_rt);
        // Without forwarding any pending writer blocks; with it only a load still in EX.
        if (src && (m == 0 || (infl[i].age == 1 && infl[i].ld))) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic bit m_at(input int m, input int a);
    foreach (infl[i]) if (infl[i].m == m && infl[i].age == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] m_wbrd(input int m);
    foreach (infl[i]) if (infl[i].m == m && infl[i].age == 3) return infl[i].rd;
    return 3'd0;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      infl.delete();
      mcnt[0] = 0;
      mcnt[1] = 0;
    end else begin
      mst0 = m_stall(0);
      mst1 = m_stall(1);
      for (int i = infl.size() - 1; i >= 0; i--) begin
        if (infl[i].age == 3 || (flush && infl[i].age == 1)) infl.delete(i);
        else infl[i].age = infl[i].age + 1;
      end
      if (id_valid && id_we && !flush) begin
        nw.rd = id_rd; nw.ld = id_is_load; nw.age = 1;
        if (!mst0) begin nw.m = 0; infl.push_back(nw); end
        if (!mst1) begin nw.m = 1; infl.push_back(nw); end
      end
      if (clr_cnt) begin
        mcnt[0] = 0;
        mcnt[1] = 0;
      end else begin
        if (mst0 && mcnt[0] < 65535) mcnt[0] = mcnt[0] + 1;
        if (mst1 && mcnt[1] < 65535) mcnt[1] = mcnt[1] + 1;
      end
    end
  end

  task automatic cmp_dut(input int m, input logic st, input logic ev, input logic mv,
                         input logic wv, input logic we, input logic [2:0] wr,
                         input logic [15:0] c);
    chk($sformatf("m%0d_stall", m), st, m_stall(m));
    chk($sformatf("m%0d_ex_vld", m), ev, m_at(m, 1));
    chk($sformatf("m%0d_mem_vld", m), mv, m_at(m, 2));
    chk($sformatf("m%0d_wb_vld", m), wv, m_at(m, 3));
    chk($sformatf("m%0d_wb_we", m), we, m_at(m, 3));
    chk($sformatf("m%0d_wb_rd", m), wr, m_wbrd(m));
    chk($sformatf("m%0d_stall_cnt", m), c, mcnt[m][15:0]);
  endtask

  initial forever begin
    @(negedge clk);
    cmp_dut(0, if0.stall, if0.ex_vld, if0.mem_vld, if0.wb_vld, if0.wb_we, if0.wb_rd, if0.stall_cnt);
    cmp_dut(1, if1.stall, if1.ex_vld, if1.mem_vld, if1.wb_vld, if1.wb_we, if1.wb_rd, if1.stall_cnt);
  end

  // ---------------- stimulus ----------------
  task automatic set(input logic v, input logic [2:0] rd, input logic we, input logic ld,
                     input logic [2:0] rs, input logic rsu, input logic [2:0] rt, input logic rtu);
    id_valid = v; id_rd = rd; id_we = we; id_is_load = ld;
    id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
  endtask

  task automatic idle();
    set(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    idle();
    repeat (n) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, tests %0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    flush = 1'b0;
    clr_cnt = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall0", if0.stall, 1'b0);
    chk("rst_vld0", {if0.ex_vld, if0.mem_vld, if0.wb_vld, if0.wb_we}, 4'b0);
    chk("rst_cnt0", if0.stall_cnt, 16'd0);
    chk("rst_wbrd1", if1.wb_rd, 3'd0);
    rst_n = 1'b1;
    tick();

    // ADD r3 then a reader of r3
    set(1, 3'd3, 1, 0, 3'd0, 0, 3'd0, 0);
    tick();
    set(1, 3'd4, 1, 0, 3'd3, 1, 3'd0, 0);
    #3 chk("add_dep_stall_c1_nofwd", if0.stall, 1'b1);
    chk("add_dep_stall_fwd", if1.stall, 1'b0);
    tick();
    #3 chk("add_dep_stall_c2_nofwd", if0.stall, 1'b1);
    tick();
    #3 chk("add_dep_stall_c3_nofwd", if0.stall, 1'b1);
    chk("add_dep_wb_we", if0.wb_we, 1'b1);
    chk("add_dep_wb_rd", if0.wb_rd, 3'd3);
    tick();
    #3 chk("add_dep_release", if0.stall, 1'b0);
    chk("add_dep_cnt_nofwd", if0.stall_cnt, 16'd3);
    chk("add_dep_cnt_fwd", if1.stall_cnt, 16'd0);
    tick();
    drain(4);

    // LD r5 then a reader of r5 through rt
    set(1, 3'd5, 1, 1, 3'd0, 0, 3'd0, 0);
    tick();
    set(1, 3'd6, 1, 0, 3'd0, 0, 3'd5, 1);
    #3 chk("ld_use_stall_fwd", if1.stall, 1'b1);
    tick();
    #3 chk("ld_use_release_fwd", if1.stall, 1'b0);
    chk("ld_use_cnt_fwd", if1.stall_cnt, 16'd1);
    tick();
    drain(4);

    // ADD r5 then reader of r5: forwarding covers it
    set(1, 3'd5, 1, 0, 3'd0, 0, 3'd0, 0);
    tick();
    set(1, 3'd1, 1, 0, 3'd5, 1, 3'd0, 0);
    #3 chk("add_r5_fwd_nostall", if1.stall, 1'b0);
    tick();
    drain(4);

    // Branch (no write) then an independent writer of r2
    set(1, 3'd1, 0, 0, 3'd0, 1, 3'd0, 0);
    #3 chk("br_stall", if0.stall, 1'b0);
    tick();
    set(1, 3'd2, 1, 0, 3'd6, 1, 3'd6, 1);
    #3 chk("br_no_slot", if0.ex_vld, 1'b0);
    chk("indep_stall", if0.stall, 1'b0);
    tick();
    idle();
    tick();
    #3 chk("br_wb_we_nofwd", if0.wb_we, 1'b0);
    chk("br_wb_we_fwd", if1.wb_we, 1'b0);
    tick();
    #3 chk("indep_wb_we", if0.wb_we, 1'b1);
    chk("indep_wb_rd", if0.wb_rd, 3'd2);
    drain(3);

    // Writer r2 in EX, flush while a reader of r2 waits
    set(1, 3'd2, 1, 0, 3'd0, 0, 3'd0, 0);
    tick();
    set(1, 3'd1, 1, 0, 3'd2, 1, 3'd0, 0);
    flush = 1'b1;
    #3 chk("flush_wins_stall", if0.stall, 1'b0);
    chk("flush_pre_ex", if0.ex_vld, 1'b1);
    tick();
    flush = 1'b0;
    #3 chk("flush_ex_vld", if0.ex_vld, 1'b0);
    chk("flush_mem_vld", if0.mem_vld, 1'b0);
    chk("flush_reader_free", if0.stall, 1'b0);
    tick();
    drain(4);

    // Counter saturation and clear with stall pending
    force dut0.stall_cnt_r = 16'hFFFE;
    mcnt[0] = 65534;
    #1 release dut0.stall_cnt_r;
    set(1, 3'd3, 1, 0, 3'd0, 0, 3'd0, 0);
    #1 chk("sat_preload", if0.stall_cnt, 16'hFFFE);
    tick();
    set(1, 3'd1, 1, 0, 3'd3, 1, 3'd0, 0);
    #3 chk("sat_stall", if0.stall, 1'b1);
    tick();
    #3 chk("sat_reach", if0.stall_cnt, 16'hFFFF);
    tick();
    #3 chk("sat_hold1", if0.stall_cnt, 16'hFFFF);
    tick();
    #3 chk("sat_hold2", if0.stall_cnt, 16'hFFFF);
    tick();
    set(1, 3'd4, 1, 0, 3'd0, 0, 3'd0, 0);
    tick();
    set(1, 3'd5, 1, 0, 3'd4, 1, 3'd0, 0);
    clr_cnt = 1'b1;
    #3 chk("clr_with_stall", if0.stall, 1'b1);
    tick();
    clr_cnt = 1'b0;
    #3 chk("clr_cnt0", if0.stall_cnt, 16'd0);
    tick();
    #3 chk("clr_then_inc", if0.stall_cnt, 16'd1);
    tick();
    drain(4);

    // Fill all slots, then drop reset between edges
    set(1, 3'd1, 1, 0, 3'd0, 0, 3'd0, 0); tick();
    set(1, 3'd2, 1, 0, 3'd0, 0, 3'd0, 0); tick();
    set(1, 3'd3, 1, 0, 3'd0, 0, 3'd0, 0); tick();
    set(1, 3'd4, 1, 0, 3'd1, 1, 3'd0, 0);
    #1 chk("full_vld", {if0.ex_vld, if0.mem_vld, if0.wb_vld}, 3'b111);
    chk("full_stall", if0.stall, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("async_rst_stall", {if0.stall, if1.stall}, 2'b00);
    chk("async_rst_vld", {if0.ex_vld, if0.mem_vld, if0.wb_vld, if0.wb_we}, 4'b0);
    chk("async_rst_wbrd", if0.wb_rd, 3'd0);
    chk("async_rst_cnt", if0.stall_cnt, 16'd0);
    tick();
    rst_n = 1'b1;
    #3 chk("post_rst_empty", if0.stall, 1'b0);
    tick();
    set(1, 3'd7, 1, 0, 3'd0, 0, 3'd0, 0);
    tick();
    set(1, 3'd6, 1, 0, 3'd7, 0, 3'd7, 0);
    #3 chk("unused_src_nofwd", if0.stall, 1'b0);
    chk("unused_src_fwd", if1.stall, 1'b0);
    tick();
    drain(4);

    // R0 is an ordinary register; rs==rt is a single hazard
    set(1, 3'd0, 1, 0, 3'd0, 0, 3'd0, 0);
    tick();
    set(1, 3'd6, 1, 0, 3'd0, 1, 3'd0, 1);
    #3 chk("r0_stall_nofwd", if0.stall, 1'b1);
    chk("r0_stall_fwd", if1.stall, 1'b0);
    tick();
    drain(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
